// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: multiply sequencer states and register-index geometry.
package pipeline_pkg;

    localparam int REG_W  = 4;
    localparam int PC_IDX = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        WB_LO = 2'd2,
        WB_HI = 2'd3
    } mul_state_t;

endpackage

// File: rtl/mul_scoreboard.sv
// Pending-destination tracker for the iterative multiplier; raises D-stage RAW/WAW stalls.
module mul_scoreboard #(
    parameter int REG_W = pipeline_pkg::REG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_en,
    input  logic             set_long,
    input  logic [REG_W-1:0] set_lo,
    input  logic [REG_W-1:0] set_hi,
    input  logic             clr_lo,
    input  logic             clr_hi,
    input  logic [REG_W-1:0] ra1,
    input  logic [REG_W-1:0] ra2,
    input  logic [REG_W-1:0] ra3,
    input  logic [REG_W-1:0] wa3,
    input  logic             reg_write,
    output logic [REG_W-1:0] rd_lo,
    output logic [REG_W-1:0] rd_hi,
    output logic             stall
);

    logic v_lo;
    logic v_hi;

    // Pending bits are registered, so a destination stops stalling the cycle after its grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_lo  <= 1'b0;
            v_hi  <= 1'b0;
            rd_lo <= '0;
            rd_hi <= '0;
        end else if (set_en) begin
            v_lo  <= 1'b1;
            v_hi  <= set_long;
            rd_lo <= set_lo;
            rd_hi <= set_hi;
        end else begin
            if (clr_lo) v_lo <= 1'b0;
            if (clr_hi) v_hi <= 1'b0;
        end
    end

    function automatic logic pending_hit(
        input logic [REG_W-1:0] idx,
        input logic             vl,
        input logic [REG_W-1:0] lo,
        input logic             vh,
        input logic [REG_W-1:0] hi
    );
        return (vl && (idx == lo)) || (vh && (idx == hi));
    endfunction

    always_comb begin
        stall = pending_hit(ra1, v_lo, rd_lo, v_hi, rd_hi)
              | pending_hit(ra2, v_lo, rd_lo, v_hi, rd_hi)
              | pending_hit(ra3, v_lo, rd_lo, v_hi, rd_hi)
              | (reg_write & pending_hit(wa3, v_lo, rd_lo, v_hi, rd_hi));
    end

endmodule

// File: rtl/mul_sequencer.sv
// Control FSM for the shift-add multiplier: load, step, then write back Lo (and Hi for long forms).
module mul_sequencer #(
    parameter int MUL_CYCLES  = 4,
    parameter int LMUL_CYCLES = 6,
    parameter int REG_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StartE,
    input  logic             LongE,
    input  logic [REG_W-1:0] RdLoE,
    input  logic [REG_W-1:0] RdHiE,
    input  logic [REG_W-1:0] RA1D,
    input  logic [REG_W-1:0] RA2D,
    input  logic [REG_W-1:0] RA3D,
    input  logic [REG_W-1:0] WA3D,
    input  logic             RegWriteD,
    input  logic             WbGnt,
    output logic             MulLoad,
    output logic             MulStep,
    output logic             WbReq,
    output logic             WbHi,
    output logic [REG_W-1:0] MulWA3,
    output logic             MulBusy,
    output logic             MulStallE,
    output logic             MulStallD
);

    import pipeline_pkg::*;

    localparam logic [3:0] MUL_LOAD  = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] LMUL_LOAD = 4'(LMUL_CYCLES - 1);

    mul_state_t       state;
    logic [3:0]       cnt;
    logic             is_long;
    logic             accept;
    logic [REG_W-1:0] rd_lo;
    logic [REG_W-1:0] rd_hi;

    assign accept = StartE && (state == IDLE);

    // The counter is loaded with cycles-1 so RUN lasts exactly the configured number of steps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            is_long <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (StartE) begin
                        is_long <= LongE;
                        cnt     <= LongE ? LMUL_LOAD : MUL_LOAD;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (cnt == 4'd0) state <= WB_LO;
                    else             cnt   <= cnt - 4'd1;
                end
                WB_LO: begin
                    if (WbGnt) state <= is_long ? WB_HI : IDLE;
                end
                WB_HI: begin
                    if (WbGnt) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // MulLoad is gated by reset so every output reads 0 while reset is held.
    assign MulLoad   = accept && reset;
    assign MulStep   = (state == RUN);
    assign WbReq     = (state == WB_LO) || (state == WB_HI);
    assign WbHi      = (state == WB_HI);
    assign MulBusy   = (state != IDLE);
    assign MulStallE = StartE && (state != IDLE);

    always_comb begin
        MulWA3 = '0;
        if (state == WB_LO)      MulWA3 = rd_lo;
        else if (state == WB_HI) MulWA3 = rd_hi;
    end

    mul_scoreboard #(
        .REG_W (REG_W)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .set_en    (accept),
        .set_long  (LongE),
        .set_lo    (RdLoE),
        .set_hi    (RdHiE),
        .clr_lo    ((state == WB_LO) && WbGnt),
        .clr_hi    ((state == WB_HI) && WbGnt),
        .ra1       (RA1D),
        .ra2       (RA2D),
        .ra3       (RA3D),
        .wa3       (WA3D),
        .reg_write (RegWriteD),
        .rd_lo     (rd_lo),
        .rd_hi     (rd_hi),
        .stall     (MulStallD)
    );

endmodule
